// File: rtl/uart_cts_tx_pkg.sv
// Shared definitions for the UART transmitter: default rates, bit-period helper and FSM states.
// Build option: define UART_TX_PARITY_EN to add an even-parity bit to every frame.
package uart_cts_tx_pkg;

    localparam int DEF_CLK = 28_000_000;
    localparam int DEF_BPS = 115_200;

    // Clocks per line bit; callers must keep the result >= 4.
    function automatic int calc_period(input int clk_hz, input int bps);
        return clk_hz / bps;
    endfunction

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        BIT    = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } tx_state_e;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        BIT   = 3'd2,
        STOP  = 3'd3
    } tx_state_e;
`endif

endpackage

// File: rtl/uart_cts_tx_if.sv
// CPU-side port bundle of the flow-controlled UART transmitter.
// Build option UART_TX_PARITY_EN does not change this interface.
interface uart_cts_tx_if #(
    parameter int FIFO_AW = 4
);
    logic [7:0]       txdata;
    logic             txwrite;
    logic             txfull;
    logic             txempty;
    logic             txbusy;
    logic [FIFO_AW:0] level;

    modport master (
        output txdata, txwrite,
        input  txfull, txempty, txbusy, level
    );

    modport slave (
        input  txdata, txwrite,
        output txfull, txempty, txbusy, level
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO with first-word-fall-through output, feeding the UART serializer.
// Build option UART_TX_PARITY_EN does not affect this block.
module uart_tx_fifo #(
    parameter int FIFO_AW = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [7:0]       din,
    output logic [7:0]       dout,
    output logic             full,
    output logic             empty,
    output logic [FIFO_AW:0] level
);
    localparam int DEPTH = 1 << FIFO_AW;

    logic [7:0]       mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Full/empty come from registered pointers, so a push while full is
    // dropped even if a pop happens on the same edge.
    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == {1'b1, {FIFO_AW{1'b0}}});
    assign empty   = (wr_ptr == rd_ptr);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rd_ptr[FIFO_AW-1:0]];

    // NOTE: storage has no reset; empty/level are defined by the pointers alone,
    // so stale contents are never observable and the array can map to plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= din;
        end
    end

    // NOTE: every register assigned with <= so all pointers update from the
    // pre-edge values and the order of statements does not matter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/uart_cts_tx.sv
// Buffered 8N1 UART transmitter that only launches a frame while the peer's cts is low.
// Build option: define UART_TX_PARITY_EN for 8E1 framing (even parity between data and stop).
module uart_cts_tx
    import uart_cts_tx_pkg::*;
#(
    parameter int CLK     = DEF_CLK,
    parameter int BPS     = DEF_BPS,
    parameter int FIFO_AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_cts_tx_if.slave  bus,
    input  logic          cts,
    output logic          tx
);
    localparam int PERIOD = calc_period(CLK, BPS);
    localparam int CW     = $clog2(PERIOD);
    localparam logic [CW-1:0] RELOAD = CW'(PERIOD - 1);

    tx_state_e  state;
    logic [CW-1:0] cnt;
    logic [2:0] bitcnt;
    logic [7:0] shift;
    logic [1:0] cts_q;
    logic       cts_s;
    logic       fifo_empty;
    logic [7:0] fifo_dout;
    logic       can_launch;
    logic       pop;
`ifdef UART_TX_PARITY_EN
    logic       par;
`endif

    uart_tx_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.txwrite),
        .pop   (pop),
        .din   (bus.txdata),
        .dout  (fifo_dout),
        .full  (bus.txfull),
        .empty (fifo_empty),
        .level (bus.level)
    );

    assign bus.txempty = fifo_empty;
    assign bus.txbusy  = (state != IDLE) | ~fifo_empty;

    // cts only matters at a launch point; mid-frame changes are ignored.
    assign cts_s      = cts_q[1];
    assign can_launch = ~fifo_empty & ~cts_s;
    assign pop        = can_launch & ((state == IDLE) | ((state == STOP) & (cnt == '0)));

    // Reset value 2'b11 treats the peer as busy until it is seen idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cts_q <= 2'b11;
        else        cts_q <= {cts_q[0], cts};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            tx     <= 1'b1;
            cnt    <= '0;
            bitcnt <= '0;
            shift  <= '0;
`ifdef UART_TX_PARITY_EN
            par    <= 1'b0;
`endif
        end else begin
            if (pop) begin
                // Launch from IDLE, or back-to-back from the last STOP clock.
                state <= START;
                tx    <= 1'b0;
                shift <= fifo_dout;
                cnt   <= RELOAD;
`ifdef UART_TX_PARITY_EN
                par   <= ^fifo_dout;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        tx <= 1'b1;
                    end
                    START: begin
                        if (cnt == '0) begin
                            state  <= BIT;
                            tx     <= shift[0];
                            bitcnt <= 3'd7;
                            cnt    <= RELOAD;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    BIT: begin
                        if (cnt == '0) begin
                            cnt <= RELOAD;
                            if (bitcnt == '0) begin
`ifdef UART_TX_PARITY_EN
                                state <= PARITY;
                                tx    <= par;
`else
                                state <= STOP;
                                tx    <= 1'b1;
`endif
                            end else begin
                                shift  <= shift >> 1;
                                tx     <= shift[1];
                                bitcnt <= bitcnt - 1'b1;
                            end
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: begin
                        if (cnt == '0) begin
                            state <= STOP;
                            tx    <= 1'b1;
                            cnt   <= RELOAD;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
`endif
                    STOP: begin
                        if (cnt == '0) begin
                            state <= IDLE;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_cts_tx.sv
// Directed bench for uart_cts_tx at PERIOD=16; a line monitor checks every frame against a scoreboard.
// Honours UART_TX_PARITY_EN to expect 8E1 framing.
module tb_uart_cts_tx;

    localparam int PERIOD = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME = FRAME_BITS * PERIOD;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic cts   = 1'b1;
    logic tx;

    int   cyc = 0;
    int   n_asserts = 0;
    int   n_fail = 0;
    logic [7:0] sb[$];
    int   fall_cyc[$];

    uart_cts_tx_if #(.FIFO_AW(4)) bus ();

    uart_cts_tx #(.CLK(1600), .BPS(100), .FIFO_AW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .cts   (cts),
        .tx    (tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input bit accept, output int wcyc);
        bus.txdata  = d;
        bus.txwrite = 1'b1;
        @(posedge clk);
        #1;
        bus.txwrite = 1'b0;
        wcyc = cyc;
        if (accept) sb.push_back(d);
    endtask

    task automatic wait_frames(input int target, input int budget);
        int k = 0;
        while (fall_cyc.size() < target && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("frames_seen", fall_cyc.size(), target);
    endtask

    task automatic wait_idle(input int budget, output int at);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.txbusy !== 1'b0 && k < budget);
        at = cyc;
        check("idle_reached", bus.txbusy, 1'b0);
    endtask

    // Line monitor: every negedge of a frame is compared to the ideal waveform.
    logic [FRAME_BITS-1:0] pat;
    logic [7:0] exp_b;
    logic [7:0] got_b;
    bit   known;
    bit   aborted;
    int   bad;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n && tx === 1'b0) begin
                fall_cyc.push_back(cyc);
                known = (sb.size() != 0);
                check("frame_expected", known, 1'b1);
                exp_b = known ? sb.pop_front() : 8'h00;
                pat = '1;
                pat[0] = 1'b0;
                pat[8:1] = exp_b;
`ifdef UART_TX_PARITY_EN
                pat[9] = ^exp_b;
`endif
                bad = 0;
                got_b = '0;
                aborted = 1'b0;
                for (int j = 0; j < FRAME; j++) begin
                    if (j > 0) @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (tx !== pat[j / PERIOD]) bad++;
                    if (j % PERIOD == PERIOD / 2 && j / PERIOD >= 1 && j / PERIOD <= 8)
                        got_b[j / PERIOD - 1] = tx;
                end
                if (!aborted && known) begin
                    check("frame_data", got_b, exp_b);
                    check("frame_timing", bad, 0);
                end
            end
        end
    end

    initial begin
        int w;
        int base;
        int at;
        int rel;
        int lows;

        bus.txwrite = 1'b0;
        bus.txdata  = 8'h00;

        // Reset values
        #12;
        check("rst_tx", tx, 1'b1);
        check("rst_txfull", bus.txfull, 1'b0);
        check("rst_txempty", bus.txempty, 1'b1);
        check("rst_txbusy", bus.txbusy, 1'b0);
        check("rst_level", bus.level, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: single byte, latency and frame length
        cts = 1'b0;
        repeat (4) @(negedge clk);
        base = fall_cyc.size();
        push(8'hA5, 1'b1, w);
        wait_frames(base + 1, 50);
        check("t1_latency", fall_cyc[base] - w, 1);
        wait_idle(FRAME + 100, at);
        check("t1_busy_fall", at - fall_cyc[base], FRAME);

        // 2: back-to-back frames with no idle gap
        base = fall_cyc.size();
        push(8'h00, 1'b1, w);
        push(8'hFF, 1'b1, w);
        wait_frames(base + 1, 50);
        check("t2_empty_after_pop1", bus.txempty, 1'b0);
        wait_frames(base + 2, FRAME + 50);
        check("t2_back_to_back", fall_cyc[base + 1] - fall_cyc[base], FRAME);
        check("t2_empty_after_pop2", bus.txempty, 1'b1);
        wait_idle(FRAME + 100, at);
        check("t2_total", at - fall_cyc[base], 2 * FRAME);

        // 3: fill while held off, overflow byte dropped, then drain in order
        cts = 1'b1;
        repeat (3) @(negedge clk);
        base = fall_cyc.size();
        for (int i = 1; i <= 16; i++) push(8'(i), 1'b1, w);
        check("t3_full", bus.txfull, 1'b1);
        check("t3_level16", bus.level, 5'd16);
        check("t3_not_empty", bus.txempty, 1'b0);
        push(8'h11, 1'b0, w);
        check("t3_level_after_drop", bus.level, 5'd16);
        repeat (20) @(negedge clk);
        check("t3_tx_held", tx, 1'b1);
        check("t3_no_frames", fall_cyc.size(), base);
        cts = 1'b0;
        wait_frames(base + 16, 16 * FRAME + 100);
        wait_idle(FRAME + 100, at);
        check("t3_sb_drained", sb.size(), 0);
        check("t3_level0", bus.level, 5'd0);
        check("t3_not_full", bus.txfull, 1'b0);

        // 4: cts raised mid-frame; frame completes, next waits for release
        base = fall_cyc.size();
        push(8'h3C, 1'b1, w);
        push(8'hC3, 1'b1, w);
        wait_frames(base + 1, 50);
        repeat (40) @(negedge clk);
        cts = 1'b1;
        repeat (FRAME + 60) @(negedge clk);
        #1;
        check("t4_held_frames", fall_cyc.size(), base + 1);
        check("t4_tx_idle", tx, 1'b1);
        check("t4_level1", bus.level, 5'd1);
        check("t4_busy", bus.txbusy, 1'b1);
        @(posedge clk);
        #1;
        cts = 1'b0;
        rel = cyc;
        wait_frames(base + 2, 50);
        check("t4_resume_delay", fall_cyc[base + 1] - rel, 3);
        wait_idle(FRAME + 100, at);

        // 5: asynchronous reset in the 4th data bit with 3 bytes queued
        base = fall_cyc.size();
        push(8'h11, 1'b1, w);
        push(8'h22, 1'b1, w);
        push(8'h33, 1'b1, w);
        push(8'h44, 1'b1, w);
        wait_frames(base + 1, 50);
        repeat (4 * PERIOD + PERIOD / 2) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_tx_async", tx, 1'b1);
        check("t5_txempty", bus.txempty, 1'b1);
        check("t5_level", bus.level, 5'd0);
        check("t5_txbusy", bus.txbusy, 1'b0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("t5_quiet_after_reset", lows, 0);
        check("t5_no_new_frames", fall_cyc.size(), base + 1);

        // 6: frame length with and without parity
        base = fall_cyc.size();
        push(8'h07, 1'b1, w);
        wait_frames(base + 1, 50);
        wait_idle(FRAME + 100, at);
        check("t6_len_07", at - fall_cyc[base], FRAME);
        base = fall_cyc.size();
        push(8'h03, 1'b1, w);
        wait_frames(base + 1, 50);
        wait_idle(FRAME + 100, at);
        check("t6_len_03", at - fall_cyc[base], FRAME);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
